// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// pll_seq_pkg : shared types and helpers for the PLL lock sequencer
// Rev 1.0
// ============================================================================
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABILIZE  = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } pll_seq_state_t;

    localparam int LOCK_LOSS_W = 8;

    // Width of the shared interval counter: wide enough for the largest terminal count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : single-bit two-flop synchronizer, async active-low reset to 0
// Rev 1.0
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// pll_lock_sequencer : holds the pixel PLL in reset, waits for stable lock,
// then releases the video reset; retries, relocks and flags hard failure.
// Rev 1.0
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                             refclk,
    input  logic                             rst_n,
    input  logic                             pll_locked,
    input  logic                             relock_req,
    output logic                             pll_rst,
    output logic                             video_rst_n,
    output logic                             ready,
    output logic                             fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [LOCK_LOSS_W-1:0]           lock_loss_cnt
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int CNT_W   = cnt_width(RST_HOLD, LOCK_STABLE, LOCK_TIMEOUT);

    localparam logic [CNT_W-1:0]   C_RST_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]   C_STB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   C_TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRIES);

    pll_seq_state_t         r_state;
    pll_seq_state_t         w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [RETRY_W-1:0]     r_retry;
    logic [RETRY_W-1:0]     w_retry_nxt;
    logic [LOCK_LOSS_W-1:0] r_llc;
    logic [LOCK_LOSS_W-1:0] w_llc_nxt;
    logic                   r_pll_rst;
    logic                   r_video_rst_n;
    logic                   r_ready;
    logic                   r_fail;
    logic                   w_lock_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_lock_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_llc_nxt   = r_llc;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_RESET_HOLD: begin
                if (r_cnt == C_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABILIZE;
                end else if (r_cnt == C_TMO_LAST) begin
                    if (r_retry == C_MAX_RETRY) begin
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = ST_RESET_HOLD;
                    end
                end
            end
            ST_STABILIZE: begin
                // A lock drop restarts the wait with a fresh timeout, not a new attempt.
                if (!w_lock_s)                w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == C_STB_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!w_lock_s || relock_req) begin
                    w_state_nxt = ST_RESET_HOLD;
                    if (r_llc != {LOCK_LOSS_W{1'b1}}) w_llc_nxt = r_llc + 1'b1;
                end
            end
            ST_FAIL: begin
                if (relock_req) begin
                    w_state_nxt = ST_RESET_HOLD;
                    w_retry_nxt = '0;
                end
            end
            default: w_state_nxt = ST_RESET_HOLD;
        endcase

        if (w_state_nxt == ST_RUN) w_retry_nxt = '0;

        // Counter only advances in the timed states; RUN and FAIL hold it.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if ((r_state == ST_RESET_HOLD) || (r_state == ST_WAIT_LOCK) ||
                     (r_state == ST_STABILIZE)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RESET_HOLD;
            r_cnt         <= '0;
            r_retry       <= '0;
            r_llc         <= '0;
            r_pll_rst     <= 1'b1;
            r_video_rst_n <= 1'b0;
            r_ready       <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_retry       <= w_retry_nxt;
            r_llc         <= w_llc_nxt;
            r_pll_rst     <= (w_state_nxt == ST_RESET_HOLD) || (w_state_nxt == ST_FAIL);
            r_video_rst_n <= (w_state_nxt == ST_RUN);
            r_ready       <= (w_state_nxt == ST_RUN);
            r_fail        <= (w_state_nxt == ST_FAIL);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign video_rst_n   = r_video_rst_n;
    assign ready         = r_ready;
    assign fail          = r_fail;
    assign retry_cnt     = r_retry;
    assign lock_loss_cnt = r_llc;

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequencer that owns the reset of the VGA pixel-clock PLL (50 MHz refclk in, 25.175644 MHz pixel clock out). It runs in the refclk domain and holds the PLL in reset for a fixed interval, then waits for a lock that stays stable. After that it releases the video pipeline reset. It retries on lock timeout, relocks on lock loss, and raises a sticky failure flag after a bounded number of retries.

## Interface
Parameters:
- RST_HOLD, 16: refclk cycles that pll_rst is held high per attempt (≥2)
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before RUN (≥2)
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK per attempt (≥2)
- MAX_RETRIES, 3: retries after the first attempt before FAIL (≥1)

Ports:
- refclk  in  1  sole clock, 50 MHz board reference
- rst_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL locked output, asynchronous to refclk
- relock_req  in  1  single-cycle request, honoured in RUN and FAIL only
- pll_rst  out  1  active-high reset to the PLL
- video_rst_n  out  1  active-low reset to the pixel-domain logic; synchronized downstream
- ready  out  1  high while in RUN
- fail  out  1  high while in FAIL
- retry_cnt  out  $clog2(MAX_RETRIES+1)  retries consumed in the current sequence
- lock_loss_cnt  out  8  saturating count of RUN→relock events

## Operation
- pll_locked passes through a 2-FF synchronizer to give lock_s (2-cycle latency).
- States: RESET_HOLD, WAIT_LOCK, STABILIZE, RUN, FAIL. One counter `cnt` is shared by the states and is cleared on every state change.
- RESET_HOLD: pll_rst=1. At cnt==RST_HOLD-1, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - lock_s=1 → STABILIZE.
  - Otherwise, at cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES → FAIL; else retry_cnt+1 and go to RESET_HOLD.
- STABILIZE:
  - lock_s=0 → WAIT_LOCK, which gets a fresh timeout. retry_cnt is unchanged.
  - At cnt==LOCK_STABLE-1 with lock_s=1 → RUN.
- RUN: ready=1, video_rst_n=1, and retry_cnt is cleared on entry.
  - lock_s=0 or relock_req → RESET_HOLD, and lock_loss_cnt+1, saturating at 255.
  - If both occur in the same cycle, only one increment happens.
- FAIL: pll_rst=1, fail=1. relock_req → RESET_HOLD with retry_cnt=0. FAIL is otherwise terminal.
- relock_req in RESET_HOLD, WAIT_LOCK or STABILIZE is ignored.
- video_rst_n=0 in every state except RUN.
- Counter width: $clog2 of the largest of RST_HOLD, LOCK_STABLE and LOCK_TIMEOUT. The counter never wraps, because every terminal compare exits the state.

## Timing
- Reset values: state=RESET_HOLD, cnt=0, pll_rst=1, video_rst_n=0, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- pll_rst pulse: exactly RST_HOLD cycles per attempt, measured from rst_n deassertion or from the transition edge.
- Lock to ready: if pll_locked rises before edge k and stays high, ready rises at edge k+2+LOCK_STABLE. This assumes WAIT_LOCK is already active.
- Lock loss in RUN: ready and video_rst_n fall 3 edges after pll_locked falls (2 synchronizer edges plus 1 transition edge).
- Timeout to FAIL with no lock: (MAX_RETRIES+1)·(RST_HOLD+LOCK_TIMEOUT) cycles after reset release.
- Reset mid-operation: rst_n low forces all reset values immediately, asynchronously. The sequence restarts from RESET_HOLD on release.

## Structure
- Package pll_seq_pkg holds:
  - the state enum (typedef pll_seq_state_t);
  - the LOCK_LOSS_W=8 constant;
  - the counter-width helper function.
- Sub-module sync_2ff: a generic single-bit 2-flop synchronizer with async active-low reset. It is reused by the video-domain reset synchronizer.
- Top level contains the FSM, the shared counter and the two status counters.

## Test plan
Bench parameters: RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
- Release rst_n; pll_locked rises before edge 10 and stays high → pll_rst high for edges 0–3, ready=1 from edge 20, retry_cnt=0.
- pll_locked held 0 → pll_rst pulses 3 times, retry_cnt steps 1 then 2, fail=1 at edge 108, pll_rst=1 thereafter.
- 1-cycle drop of pll_locked at STABILIZE cnt=5 → state goes back to WAIT_LOCK; ready rises only after 8 new consecutive lock_s cycles; retry_cnt unchanged.
- In RUN, drop pll_locked → ready and video_rst_n fall 3 edges later, 4-cycle pll_rst pulse, lock_loss_cnt=1; restoring lock returns to RUN.
- relock_req coincident with the lock_s falling edge in RUN → lock_loss_cnt increments by exactly 1. Later, relock_req in FAIL → fail=0, retry_cnt=0, new pll_rst pulse.
- Assert rst_n low mid-STABILIZE and mid-RUN → all outputs take reset values with no clock edge; 256 lock losses leave lock_loss_cnt=255.
